// File: rtl/gpio_bus_arbiter_if.sv
// Bus bundle between the GPIO header arbiter and its users.
// Optional lock inputs are present only when GPIO_ARB_LOCK_EN is defined.
//
// Handshake: a requester raises reqN together with weN/wdataN and keeps req
// high until ackN. ackN is a single-cycle pulse, and the requester must drop
// reqN during that ack cycle. The arbiter latches we/wdata on the grant edge,
// so later changes to them are ignored. If req is dropped after the grant the
// transaction still runs to completion and still acks.
interface gpio_bus_arbiter_if #(
  parameter int WIDTH = 32
);
  logic             req0;
  logic             we0;
  logic [WIDTH-1:0] wdata0;
  logic             ack0;
  logic             req1;
  logic             we1;
  logic [WIDTH-1:0] wdata1;
  logic             ack1;
`ifdef GPIO_ARB_LOCK_EN
  logic             lock0;
  logic             lock1;
`endif
  logic [WIDTH-1:0] rdata;
  logic [WIDTH-1:0] gpio_in;
  logic [WIDTH-1:0] gpio_out;
  logic             gpio_oe;
  logic             busy;
  logic [2:0]       dbg_state;

`ifdef GPIO_ARB_LOCK_EN
  modport master (
    output req0, we0, wdata0, req1, we1, wdata1, lock0, lock1, gpio_in,
    input  ack0, ack1, rdata, gpio_out, gpio_oe, busy, dbg_state
  );
  modport slave (
    input  req0, we0, wdata0, req1, we1, wdata1, lock0, lock1, gpio_in,
    output ack0, ack1, rdata, gpio_out, gpio_oe, busy, dbg_state
  );
`else
  modport master (
    output req0, we0, wdata0, req1, we1, wdata1, gpio_in,
    input  ack0, ack1, rdata, gpio_out, gpio_oe, busy, dbg_state
  );
  modport slave (
    input  req0, we0, wdata0, req1, we1, wdata1, gpio_in,
    output ack0, ack1, rdata, gpio_out, gpio_oe, busy, dbg_state
  );
`endif
endinterface

// File: rtl/gpio_bus_arbiter.sv
// Two-requester round-robin arbiter for the shared bidirectional GPIO header.
// Inserts turnaround cycles on direction changes, holds write data for a fixed
// time, and samples reads through a 2-flop synchroniser.
// After a write the bus stays parked (driven) until a read forces a turnaround.
// Optional macro GPIO_ARB_LOCK_EN adds lock0/lock1, which let the current
// owner win the next tie.
module gpio_bus_arbiter #(
  parameter int WIDTH       = 32,
  parameter int TURN_CYCLES = 2,
  parameter int HOLD_CYCLES = 4
) (
  input logic               CLOCK_50,
  input logic               Resetn,
  gpio_bus_arbiter_if.slave bus
);

  typedef enum logic [2:0] {IDLE, TURN, DRIVE, SAMPLE, DONE} state_t;

  localparam int SAMPLE_CYCLES = 3;
  localparam int MAX_TH  = (TURN_CYCLES > HOLD_CYCLES) ? TURN_CYCLES : HOLD_CYCLES;
  localparam int CNT_MAX = (MAX_TH > SAMPLE_CYCLES) ? MAX_TH : SAMPLE_CYCLES;
  localparam int CW      = $clog2(CNT_MAX + 1);

  localparam logic [CW-1:0] TURN_LOAD   = CW'(TURN_CYCLES - 1);
  localparam logic [CW-1:0] HOLD_LOAD   = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] SAMPLE_LOAD = CW'(SAMPLE_CYCLES - 1);

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             gnt_q, gnt_d;
  logic             we_q, we_d;
  logic [WIDTH-1:0] wdata_q, wdata_d;
  logic             last_grant_q, last_grant_d;
  logic             oe_q, oe_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic [WIDTH-1:0] rdata_q, rdata_d;
  logic [WIDTH-1:0] sync1_q, sync2_q;

  logic             pick;
  logic             pick_we;
  logic [WIDTH-1:0] pick_wdata;
  logic             lock_sel;

  // On a tie the requester that did not win last time gets the bus.
  assign pick       = (bus.req0 && bus.req1) ? ~last_grant_q : ~bus.req0;
  assign pick_we    = pick ? bus.we1 : bus.we0;
  assign pick_wdata = pick ? bus.wdata1 : bus.wdata0;

  // A lock is only looked at in DONE. If the locked requester then lets req
  // go low, the other requester simply wins in IDLE as the only one pending.
`ifdef GPIO_ARB_LOCK_EN
  assign lock_sel = gnt_q ? bus.lock1 : bus.lock0;
`else
  assign lock_sel = 1'b0;
`endif

  // Raw pins are asynchronous; the two-stage synchroniser runs every cycle.
  always_ff @(posedge CLOCK_50 or negedge Resetn) begin
    if (!Resetn) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= bus.gpio_in;
      sync2_q <= sync1_q;
    end
  end

  // State and datapath registers. Async reset releases the bus immediately.
  always_ff @(posedge CLOCK_50 or negedge Resetn) begin
    if (!Resetn) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      gnt_q        <= 1'b0;
      we_q         <= 1'b0;
      wdata_q      <= '0;
      last_grant_q <= 1'b1;
      oe_q         <= 1'b0;
      out_q        <= '0;
      rdata_q      <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      gnt_q        <= gnt_d;
      we_q         <= we_d;
      wdata_q      <= wdata_d;
      last_grant_q <= last_grant_d;
      oe_q         <= oe_d;
      out_q        <= out_d;
      rdata_q      <= rdata_d;
    end
  end

  // Next-state logic. Each counter is reloaded on entry to its state and
  // counts down to zero.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    gnt_d        = gnt_q;
    we_d         = we_q;
    wdata_d      = wdata_q;
    last_grant_d = last_grant_q;
    oe_d         = oe_q;
    out_d        = out_q;
    rdata_d      = rdata_q;
    case (state_q)
      IDLE: begin
        if (bus.req0 || bus.req1) begin
          gnt_d   = pick;
          we_d    = pick_we;
          wdata_d = pick_wdata;
          if (pick_we && oe_q) begin
            // The bus is already driven, so no turnaround is needed.
            state_d = DRIVE;
            cnt_d   = HOLD_LOAD;
            out_d   = pick_wdata;
          end else if (!pick_we && !oe_q) begin
            state_d = SAMPLE;
            cnt_d   = SAMPLE_LOAD;
          end else begin
            state_d = TURN;
            cnt_d   = TURN_LOAD;
            oe_d    = 1'b0;
          end
        end
      end
      TURN: begin
        if (cnt_q == '0) begin
          if (we_q) begin
            state_d = DRIVE;
            cnt_d   = HOLD_LOAD;
            oe_d    = 1'b1;
            out_d   = wdata_q;
          end else begin
            state_d = SAMPLE;
            cnt_d   = SAMPLE_LOAD;
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      DRIVE: begin
        if (cnt_q == '0) state_d = DONE;
        else             cnt_d   = cnt_q - CW'(1);
      end
      SAMPLE: begin
        if (cnt_q == '0) begin
          rdata_d = sync2_q;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      DONE: begin
        last_grant_d = lock_sel ? ~gnt_q : gnt_q;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.ack0      = (state_q == DONE) && !gnt_q;
  assign bus.ack1      = (state_q == DONE) &&  gnt_q;
  assign bus.busy      = (state_q != IDLE);
  assign bus.gpio_oe   = oe_q;
  assign bus.gpio_out  = out_q;
  assign bus.rdata     = rdata_q;
  assign bus.dbg_state = state_q;

endmodule
